// File: rtl/adc_scan_sched.sv
// adc_scan_sched
// Sequencer and arbiter in front of the shared adc_ltc2308 conversion engine.
// Runs a background round-robin scan of NUM_CH channels and serves on-demand
// single-channel conversions for NUM_REQ requesters. Requesters are arbitrated
// fairly, and a pending request always wins over the scan.
// Optional feature: define ADC_SCAN_TIMEOUT_EN to enable a per-conversion
// watchdog of TIMEOUT_CYCLES cycles. Without it, WAIT blocks until the
// engine answers and timeout_err is tied low.

module adc_scan_sched #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_CH         = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [3*NUM_REQ-1:0]  req_ch,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [11:0]           rsp_data,
  output logic                  measure_start,
  output logic [2:0]            measure_ch,
  input  logic                  measure_done,
  input  logic [11:0]           measured_data,
  output logic [12*NUM_CH-1:0]  ch_data,
  output logic [NUM_CH-1:0]     ch_fresh,
  output logic                  timeout_err
);

  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} stateT;

  stateT               state_q, state_d;
  logic [REQ_W-1:0]    rrPtr_q, rrPtr_d;
  logic [2:0]          scanCh_q, scanCh_d;
  logic [REQ_W-1:0]    grant_q, grant_d;
  logic                isReq_q, isReq_d;
  logic [2:0]          convCh_q, convCh_d;
  logic                measureStart_q, measureStart_d;
  logic [2:0]          measureCh_q, measureCh_d;
  logic [11:0]         chData_q [NUM_CH];
  logic [11:0]         chData_d [NUM_CH];
  logic [NUM_CH-1:0]   chFresh_q, chFresh_d;
  logic [NUM_REQ-1:0]  rspValid_q, rspValid_d;
  logic                rspErr_q, rspErr_d;
  logic [11:0]         rspData_q, rspData_d;

  logic [REQ_W-1:0]    pickIdx;
  logic [REQ_W-1:0]    pickNext;
  logic [2:0]          pickCh;
  logic                pickBad;
  logic [2:0]          scanNext;

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0]     toCnt_q, toCnt_d;
  logic                timeoutErr_q, timeoutErr_d;
`else
  logic [31:0]         unusedTimeoutCfg;
  assign unusedTimeoutCfg = TIMEOUT_CYCLES;
`endif

  // First requester at or after ptr, searching circularly.
  function automatic logic [REQ_W-1:0] pickReq(input logic [NUM_REQ-1:0] reqVec,
                                               input logic [REQ_W-1:0]   ptr);
    logic [REQ_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && reqVec[idx]) begin
        found = 1'b1;
        pick  = REQ_W'(idx);
      end
    end
    return pick;
  endfunction

  assign pickIdx  = pickReq(req, rrPtr_q);
  assign pickNext = (pickIdx == REQ_W'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
  assign pickCh   = req_ch[3*int'(pickIdx) +: 3];
  assign pickBad  = (int'(pickCh) >= NUM_CH);
  assign scanNext = (scanCh_q == 3'(NUM_CH - 1)) ? 3'd0 : scanCh_q + 3'd1;

  // Next-state logic: arbitration, conversion handshake and result routing.
  always_comb begin
    state_d        = state_q;
    rrPtr_d        = rrPtr_q;
    scanCh_d       = scanCh_q;
    grant_d        = grant_q;
    isReq_d        = isReq_q;
    convCh_d       = convCh_q;
    measureStart_d = measureStart_q;
    measureCh_d    = measureCh_q;
    chData_d       = chData_q;
    chFresh_d      = '0;
    rspValid_d     = '0;
    rspErr_d       = 1'b0;
    rspData_d      = '0;
`ifdef ADC_SCAN_TIMEOUT_EN
    toCnt_d        = toCnt_q;
    timeoutErr_d   = timeoutErr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!measure_done) begin
          if (|req) begin
            grant_d = pickIdx;
            isReq_d = 1'b1;
            rrPtr_d = pickNext;
            if (pickBad) begin
              // No conversion for an out-of-range channel; answer with an error.
              rspValid_d[pickIdx] = 1'b1;
              rspErr_d            = 1'b1;
              state_d             = RELEASE;
            end else begin
              convCh_d = pickCh;
              state_d  = START;
            end
          end else if (scan_en) begin
            isReq_d  = 1'b0;
            convCh_d = scanCh_q;
            state_d  = START;
          end
        end
      end
      START: begin
        measureCh_d    = convCh_q;
        measureStart_d = 1'b1;
        state_d        = WAIT;
`ifdef ADC_SCAN_TIMEOUT_EN
        toCnt_d        = '0;
`endif
      end
      WAIT: begin
        if (measure_done) begin
          measureStart_d = 1'b0;
          for (int k = 0; k < NUM_CH; k++) begin
            if (measureCh_q == 3'(k)) begin
              chData_d[k]  = measured_data;
              chFresh_d[k] = 1'b1;
            end
          end
          if (isReq_q) begin
            rspValid_d[grant_q] = 1'b1;
            rspData_d           = measured_data;
          end else begin
            scanCh_d = scanNext;
          end
          state_d = RELEASE;
        end
`ifdef ADC_SCAN_TIMEOUT_EN
        else if (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          measureStart_d = 1'b0;
          timeoutErr_d   = 1'b1;
          if (isReq_q) begin
            rspValid_d[grant_q] = 1'b1;
            rspErr_d            = 1'b1;
          end else begin
            scanCh_d = scanNext;
          end
          state_d = RELEASE;
        end else begin
          toCnt_d = toCnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        measureStart_d = 1'b0;
        if (!measure_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rrPtr_q        <= '0;
      scanCh_q       <= '0;
      grant_q        <= '0;
      isReq_q        <= 1'b0;
      convCh_q       <= '0;
      measureStart_q <= 1'b0;
      measureCh_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) chData_q[k] <= '0;
      chFresh_q      <= '0;
      rspValid_q     <= '0;
      rspErr_q       <= 1'b0;
      rspData_q      <= '0;
`ifdef ADC_SCAN_TIMEOUT_EN
      toCnt_q        <= '0;
      timeoutErr_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rrPtr_q        <= rrPtr_d;
      scanCh_q       <= scanCh_d;
      grant_q        <= grant_d;
      isReq_q        <= isReq_d;
      convCh_q       <= convCh_d;
      measureStart_q <= measureStart_d;
      measureCh_q    <= measureCh_d;
      chData_q       <= chData_d;
      chFresh_q      <= chFresh_d;
      rspValid_q     <= rspValid_d;
      rspErr_q       <= rspErr_d;
      rspData_q      <= rspData_d;
`ifdef ADC_SCAN_TIMEOUT_EN
      toCnt_q        <= toCnt_d;
      timeoutErr_q   <= timeoutErr_d;
`endif
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : gChOut
    assign ch_data[12*k +: 12] = chData_q[k];
  end

  assign measure_start = measureStart_q;
  assign measure_ch    = measureCh_q;
  assign ch_fresh      = chFresh_q;
  assign rsp_valid     = rspValid_q;
  assign rsp_err       = rspErr_q;
  assign rsp_data      = rspData_q;
`ifdef ADC_SCAN_TIMEOUT_EN
  assign timeout_err   = timeoutErr_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed testbench for adc_scan_sched with a simple adc_ltc2308 model.
// The engine model answers three cycles after measure_start with
// 0x100 + channel (or an override value), holds done until start drops.

module tb_adc_scan_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] req_ch = '0;
  logic [3:0]  rsp_valid;
  logic        rsp_err;
  logic [11:0] rsp_data;
  logic        measure_start;
  logic [2:0]  measure_ch;
  logic        measure_done = 1'b0;
  logic [11:0] measured_data = '0;
  logic [71:0] ch_data;
  logic [5:0]  ch_fresh;
  logic        timeout_err;

  int compared = 0;
  int mismatched = 0;

  logic        engHang = 1'b0;
  logic        engOverride = 1'b0;
  logic [11:0] engOverrideData = '0;
  int          engCnt = 0;

  adc_scan_sched #(
    .NUM_REQ(4),
    .NUM_CH(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .req(req),
    .req_ch(req_ch),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_data(rsp_data),
    .measure_start(measure_start),
    .measure_ch(measure_ch),
    .measure_done(measure_done),
    .measured_data(measured_data),
    .ch_data(ch_data),
    .ch_fresh(ch_fresh),
    .timeout_err(timeout_err)
  );

  // Free-running 100 MHz-style clock
  initial forever #5 clk = ~clk;

  // Conversion engine model, updated on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      measure_done = 1'b0;
      engCnt = 0;
    end else if (measure_done) begin
      if (!measure_start) measure_done = 1'b0;
    end else if (measure_start && !engHang) begin
      engCnt = engCnt + 1;
      if (engCnt >= 3) begin
        engCnt = 0;
        measure_done = 1'b1;
        measured_data = engOverride ? engOverrideData : (12'h100 + {9'd0, measure_ch});
      end
    end
  end

  // Global safety net
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset;
    rst_n = 1'b0; scan_en = 1'b0; req = '0; req_ch = '0;
    repeat (2) @(negedge clk);
    compared++; if (measure_start !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_measure_start: got %b expected 0", measure_start); end
    compared++; if (measure_ch !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_measure_ch: got %0d expected 0", measure_ch); end
    compared++; if (rsp_valid !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    compared++; if (ch_data !== 72'd0) begin mismatched++; $display("[TB] FAIL reset_ch_data: got %h expected 0", ch_data); end
    compared++; if (ch_fresh !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_ch_fresh: got %b expected 0", ch_fresh); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic        scanLeak;
    logic        gotRsp;
    logic [3:0]  expVec;
    logic [5:0]  expFresh;
    logic [11:0] expData;
    scan_en = 1'b1;
    for (int i = 0; i < 4; i++) req_ch[3*i +: 3] = 3'(i + 1);
    req = 4'b1111;
    scanLeak = 1'b0;
    for (int n = 0; n < 4; n++) begin
      gotRsp = 1'b0;
      for (int c = 0; c < 60 && !gotRsp; c++) begin
        @(negedge clk);
        if (rsp_valid !== 4'd0) gotRsp = 1'b1;
        else if (ch_fresh !== 6'd0) scanLeak = 1'b1;
      end
      expVec = '0; expVec[n] = 1'b1;
      expFresh = '0; expFresh[n+1] = 1'b1;
      expData = 12'h101 + 12'(n);
      compared++;
      if (!gotRsp) begin
        mismatched++; $display("[TB] FAIL rr_rsp_wait%0d: got no rsp_valid expected %b", n, expVec);
      end else begin
        compared++; if (rsp_valid !== expVec) begin mismatched++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", n, rsp_valid, expVec); end
        compared++; if (rsp_data !== expData) begin mismatched++; $display("[TB] FAIL rr_data%0d: got %h expected %h", n, rsp_data, expData); end
        compared++; if (ch_fresh !== expFresh) begin mismatched++; $display("[TB] FAIL rr_fresh%0d: got %b expected %b", n, ch_fresh, expFresh); end
      end
      req[n] = 1'b0;
    end
    compared++; if (scanLeak !== 1'b0) begin mismatched++; $display("[TB] FAIL rr_scan_blocked: got scan activity %b expected 0", scanLeak); end
  endtask

  task automatic test_scan;
    logic       got;
    int         expCh;
    logic [5:0] expFresh;
    scan_en = 1'b1;
    for (int p = 0; p < 7; p++) begin
      expCh = p % 6;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (ch_fresh !== 6'd0) got = 1'b1;
      end
      expFresh = '0; expFresh[expCh] = 1'b1;
      compared++;
      if (!got) begin
        mismatched++; $display("[TB] FAIL scan_wait%0d: got no ch_fresh expected %b", p, expFresh);
      end else begin
        compared++; if (ch_fresh !== expFresh) begin mismatched++; $display("[TB] FAIL scan_fresh%0d: got %b expected %b", p, ch_fresh, expFresh); end
        compared++; if (ch_data[12*expCh +: 12] !== 12'h100 + 12'(expCh)) begin mismatched++; $display("[TB] FAIL scan_data%0d: got %h expected %h", p, ch_data[12*expCh +: 12], 12'h100 + 12'(expCh)); end
      end
    end
    scan_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single;
    logic got;
    scan_en = 1'b0;
    repeat (20) @(negedge clk);
    engOverride = 1'b1; engOverrideData = 12'hABC;
    req_ch[6 +: 3] = 3'd3;
    req[2] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (measure_start === 1'b1) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++; $display("[TB] FAIL single_start: got no measure_start expected 1");
    end else begin
      compared++; if (measure_ch !== 3'd3) begin mismatched++; $display("[TB] FAIL single_measure_ch: got %0d expected 3", measure_ch); end
    end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'd0) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++; $display("[TB] FAIL single_rsp_wait: got no rsp_valid expected 0100");
    end else begin
      compared++; if (rsp_valid !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
      compared++; if (rsp_data !== 12'hABC) begin mismatched++; $display("[TB] FAIL single_rsp_data: got %h expected abc", rsp_data); end
      compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL single_rsp_err: got %b expected 0", rsp_err); end
      compared++; if (ch_data[36 +: 12] !== 12'hABC) begin mismatched++; $display("[TB] FAIL single_ch_data: got %h expected abc", ch_data[36 +: 12]); end
      compared++; if (ch_fresh !== 6'b001000) begin mismatched++; $display("[TB] FAIL single_ch_fresh: got %b expected 001000", ch_fresh); end
    end
    req[2] = 1'b0;
    engOverride = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bad_channel;
    logic got;
    logic sawStart;
    scan_en = 1'b0;
    repeat (10) @(negedge clk);
    req_ch[3 +: 3] = 3'd7;
    req[1] = 1'b1;
    got = 1'b0; sawStart = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      @(negedge clk);
      if (measure_start === 1'b1) sawStart = 1'b1;
      if (rsp_valid !== 4'd0) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++; $display("[TB] FAIL bad_rsp_wait: got no rsp_valid within 2 cycles expected 0010");
    end else begin
      compared++; if (rsp_valid !== 4'b0010) begin mismatched++; $display("[TB] FAIL bad_rsp_valid: got %b expected 0010", rsp_valid); end
      compared++; if (rsp_err !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_rsp_err: got %b expected 1", rsp_err); end
      compared++; if (rsp_data !== 12'h000) begin mismatched++; $display("[TB] FAIL bad_rsp_data: got %h expected 000", rsp_data); end
    end
    req[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (measure_start === 1'b1) sawStart = 1'b1;
    end
    compared++; if (sawStart !== 1'b0) begin mismatched++; $display("[TB] FAIL bad_no_start: got measure_start seen %b expected 0", sawStart); end
  endtask

  task automatic test_timeout;
`ifdef ADC_SCAN_TIMEOUT_EN
    logic        got;
    int          highCnt;
    logic [11:0] oldData;
    oldData = ch_data[24 +: 12];
    engHang = 1'b1;
    req_ch[0 +: 3] = 3'd2;
    req[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (measure_start === 1'b1) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++; $display("[TB] FAIL timeout_start: got no measure_start expected 1");
    end else begin
      highCnt = 1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (measure_start === 1'b1) highCnt++;
        else break;
      end
      compared++; if (highCnt !== 16) begin mismatched++; $display("[TB] FAIL timeout_cycles: got %0d expected 16", highCnt); end
      compared++; if (rsp_valid !== 4'b0001) begin mismatched++; $display("[TB] FAIL timeout_rsp_valid: got %b expected 0001", rsp_valid); end
      compared++; if (rsp_err !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_rsp_err: got %b expected 1", rsp_err); end
      compared++; if (rsp_data !== 12'h000) begin mismatched++; $display("[TB] FAIL timeout_rsp_data: got %h expected 000", rsp_data); end
      compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_err_flag: got %b expected 1", timeout_err); end
      compared++; if (ch_data[24 +: 12] !== oldData) begin mismatched++; $display("[TB] FAIL timeout_ch_data: got %h expected %h", ch_data[24 +: 12], oldData); end
    end
    req[0] = 1'b0;
    engHang = 1'b0;
    repeat (5) @(negedge clk);
`else
    @(negedge clk);
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_err_tied: got %b expected 0", timeout_err); end
`endif
  endtask

  task automatic test_reset_mid;
    logic got;
    scan_en = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (measure_start === 1'b1) got = 1'b1;
    end
    compared++;
    if (!got) begin mismatched++; $display("[TB] FAIL rstmid_start: got no measure_start expected 1"); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++; if (measure_start !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_measure_start: got %b expected 0", measure_start); end
    compared++; if (measure_ch !== 3'd0) begin mismatched++; $display("[TB] FAIL rstmid_measure_ch: got %0d expected 0", measure_ch); end
    compared++; if (ch_data !== 72'd0) begin mismatched++; $display("[TB] FAIL rstmid_ch_data: got %h expected 0", ch_data); end
    compared++; if (rsp_valid !== 4'd0) begin mismatched++; $display("[TB] FAIL rstmid_rsp_valid: got %b expected 0000", rsp_valid); end
    compared++; if (ch_fresh !== 6'd0) begin mismatched++; $display("[TB] FAIL rstmid_ch_fresh: got %b expected 0", ch_fresh); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_timeout_err: got %b expected 0", timeout_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (measure_start === 1'b1) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++; $display("[TB] FAIL rstmid_restart: got no measure_start expected 1");
    end else begin
      compared++; if (measure_ch !== 3'd0) begin mismatched++; $display("[TB] FAIL rstmid_restart_ch: got %0d expected 0", measure_ch); end
    end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (ch_fresh !== 6'd0) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++; $display("[TB] FAIL rstmid_fresh_wait: got no ch_fresh expected 000001");
    end else begin
      compared++; if (ch_fresh !== 6'b000001) begin mismatched++; $display("[TB] FAIL rstmid_fresh: got %b expected 000001", ch_fresh); end
      compared++; if (ch_data[0 +: 12] !== 12'h100) begin mismatched++; $display("[TB] FAIL rstmid_ch0_data: got %h expected 100", ch_data[0 +: 12]); end
    end
    scan_en = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Test sequence
  initial begin
    $display("[TB] adc_scan_sched directed test start");
    test_reset;
    test_round_robin;
    test_scan;
    test_single;
    test_bad_channel;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adc_scan_sched.md
# adc_scan_sched

Sequencer and arbiter for the shared LTC2308 conversion engine (`adc_ltc2308`). It runs a background round-robin scan of the analog channels and serves on-demand single-channel conversions from up to `NUM_REQ` puzzle modules, with fair round-robin arbitration between them. It drives the engine's start/channel inputs, consumes its done/data outputs, and publishes a per-channel result bank. It sits between the puzzle logic and `adc_ltc2308`, replacing any free-running channel stepping.

## Interface
- `NUM_REQ`, 4: number of on-demand requesters (1..8).
- `NUM_CH`, 6: number of scanned channels (1..8).
- `TIMEOUT_CYCLES`, 4096: watchdog limit per conversion (only with `ADC_SCAN_TIMEOUT_EN`).

Ports:
- `clk` in 1: system clock, max 40 MHz, shared with `adc_ltc2308`.
- `rst_n` in 1: asynchronous active-low reset.
- `scan_en` in 1: enables background scan.
- `req` in `NUM_REQ`: per-requester conversion request, level, held until `rsp_valid`.
- `req_ch` in `3*NUM_REQ`: requested channel, 3 bits per requester, stable while `req` is high.
- `rsp_valid` out `NUM_REQ`: one-cycle completion pulse to the granted requester.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 means bad channel or timeout.
- `rsp_data` out 12: result; valid while any `rsp_valid` bit is high.
- `measure_start` out 1: start request to `adc_ltc2308`.
- `measure_ch` out 3: channel to `adc_ltc2308`.
- `measure_done` in 1: conversion done from `adc_ltc2308`.
- `measured_data` in 12: conversion data from `adc_ltc2308`.
- `ch_data` out `12*NUM_CH`: latest result per channel; channel k is at bits [12k+11:12k].
- `ch_fresh` out `NUM_CH`: one-cycle pulse when `ch_data` for that channel updates.
- `timeout_err` out 1: sticky; set on watchdog expiry and cleared only by reset.

## Operation
- FSM states: IDLE, START, WAIT, RELEASE.
- IDLE: arbitrate when `measure_done`=0.
  - Any `req` high: grant the first requester at or after `rr_ptr`, then set `rr_ptr` to the granted index +1 (wraps at `NUM_REQ`).
  - Otherwise, if `scan_en`=1: select `scan_ch`.
  - Otherwise stay in IDLE.
  - Requests always have priority over the scan.
- Bad channel: if the granted `req_ch` is ≥ `NUM_CH`, do not start a conversion. Next cycle pulse `rsp_valid`, set `rsp_err`=1 and `rsp_data`=0, then return to IDLE.
- START: register `measure_ch`, assert `measure_start`, go to WAIT.
- WAIT: hold `measure_start`=1 until `measure_done` is sampled high.
  - Capture `measured_data` as full 12 bits, no truncation.
  - Write it to `ch_data[measure_ch]` and pulse `ch_fresh[measure_ch]`.
  - For a request, also pulse `rsp_valid[grant]` with `rsp_err`=0.
  - For the scan, advance `scan_ch` (wraps from `NUM_CH`-1 to 0).
  - Then go to RELEASE.
- RELEASE: `measure_start`=0. Wait for `measure_done`=0, then go to IDLE.
- A request that arrives during a scan conversion waits for that conversion to finish. It is never preempted.
- Reset values:
  - State IDLE; `rr_ptr`=0, `scan_ch`=0.
  - `measure_start`=0, `measure_ch`=0.
  - All `ch_data`=0; `ch_fresh`, `rsp_valid`, `rsp_err` and `timeout_err` all 0.
- Reset asserted mid-conversion: outputs go to their reset values immediately. The result in flight is discarded and requesters must re-request.

## Timing
- Grant to `measure_start` rising edge: 1 cycle.
- `measure_done` sampled high to `rsp_valid`/`ch_fresh`: 1 cycle (registered outputs).
- Minimum gap between conversions: 2 cycles after `measure_done` falls.
- Dropping `req` before `rsp_valid` is illegal; behaviour is undefined and the bench must not do it.
- Simultaneous requests from all requesters are served in `rr_ptr` order, one per conversion.
- `rsp_valid` is never asserted for more than one requester in the same cycle.

## Configuration
- `ADC_SCAN_TIMEOUT_EN` defined: a counter runs in WAIT.
  - After `TIMEOUT_CYCLES` cycles without `measure_done`: drop `measure_start`, set `timeout_err`, go to RELEASE.
  - For a request, pulse `rsp_valid` with `rsp_err`=1 and `rsp_data`=0. For the scan, advance `scan_ch`. `ch_data` is left unchanged in both cases.
- Not defined: no counter; WAIT waits indefinitely and `timeout_err` is tied to 0.

## Test plan
- Scan: `scan_en`=1, no requests, engine model returns 0x100+ch. Required: `ch_fresh` pulses cycle through 0..5 and back to 0, and `ch_data[ch]` = 0x100+ch.
- Single request: requester 2 requests ch 3, model returns 0xABC. Required: `measure_ch`=3, then `rsp_valid`=0b0100 with `rsp_data`=0xABC and `rsp_err`=0, and `ch_data` ch3 = 0xABC.
- Round-robin: all 4 requesters request simultaneously from `rr_ptr`=0, each held until served. Required: grants in order 0,1,2,3, and the scan does not run until all 4 are done.
- Bad channel: requester 1 requests ch 7 with `NUM_CH`=6. Required: no `measure_start`, `rsp_valid`=0b0010 with `rsp_err`=1 within 2 cycles.
- Timeout (`ADC_SCAN_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): model never asserts `measure_done`. Required: `measure_start` drops after 16 cycles in WAIT, `timeout_err`=1, `rsp_err`=1.
- Reset: pulse `rst_n` low while in WAIT. Required: `measure_start`=0 immediately and all outputs at their reset values; after release the scan restarts at ch 0.
